// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle: memory-stage inputs and writeback outputs.
// master drives the MEM side; slave is the mem_wb_stage itself.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              reg_write_in;
  logic              mem_to_reg_in;
  logic [2:0]        load_type_in;
  logic [1:0]        byte_off_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] mem_data_in;
  logic [REG_AW-1:0] rd_in;

  logic              wb_valid;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_misalign;

  modport master (
    output in_valid, reg_write_in, mem_to_reg_in,
    output load_type_in, byte_off_in,
    output alu_result_in, mem_data_in, rd_in,
    input  wb_valid, wb_reg_write, wb_rd,
    input  wb_data, wb_misalign
  );

  modport slave (
    input  in_valid, reg_write_in, mem_to_reg_in,
    input  load_type_in, byte_off_in,
    input  alu_result_in, mem_data_in, rd_in,
    output wb_valid, wb_reg_write, wb_rd,
    output wb_data, wb_misalign
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB register with load extraction, misalign detect, WB select.
// Ports: clk, reset (sync, high), stall, flush, bus (slave side).
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  mem_wb_stage_if.slave bus
);

  logic [DATA_W-1:0] mem;
  logic [1:0]        off;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              is_lb;
  logic              is_lh;
  logic              is_lbu;
  logic              is_lhu;
  logic [DATA_W-1:0] load_val;
  logic              mis_raw;
  logic              misalign;
  logic              we_d;
  logic [DATA_W-1:0] data_d;

  logic              valid_q;
  logic              we_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic              mis_q;

  assign mem = bus.mem_data_in;
  assign off = bus.byte_off_in;

  assign is_lb  = (bus.load_type_in == 3'b000);
  assign is_lh  = (bus.load_type_in == 3'b001);
  assign is_lbu = (bus.load_type_in == 3'b100);
  assign is_lhu = (bus.load_type_in == 3'b101);

  always_comb begin
    byte_sel = mem[7:0];
    unique case (off)
      2'd0: byte_sel = mem[7:0];
      2'd1: byte_sel = mem[15:8];
      2'd2: byte_sel = mem[23:16];
      2'd3: byte_sel = mem[31:24];
    endcase
  end

  // Odd halfword offsets are misaligned; only off[1] picks the half.
  assign half_sel = off[1] ? mem[31:16] : mem[15:0];

  always_comb begin
    load_val = mem;
    unique case (1'b1)
      is_lb:   load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      is_lh:   load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
      is_lbu:  load_val = {{(DATA_W-8){1'b0}}, byte_sel};
      is_lhu:  load_val = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_val = mem;
    endcase
  end

  // Reserved load codes behave as LW, alignment included.
  always_comb begin
    mis_raw = 1'b0;
    unique case (1'b1)
      is_lb | is_lbu: mis_raw = 1'b0;
      is_lh | is_lhu: mis_raw = off[0];
      default:        mis_raw = |off;
    endcase
  end

  assign misalign = bus.in_valid & bus.mem_to_reg_in & mis_raw;

  assign we_d = bus.in_valid & bus.reg_write_in
              & (bus.rd_in != '0) & ~misalign;

  assign data_d = bus.mem_to_reg_in ? load_val : bus.alu_result_in;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= bus.in_valid;
      we_q    <= we_d;
      rd_q    <= bus.rd_in;
      data_q  <= data_d;
      mis_q   <= misalign;
    end
  end

  assign bus.wb_valid     = valid_q;
  assign bus.wb_reg_write = we_q;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = data_q;
  assign bus.wb_misalign  = mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed + random scoreboard bench for mem_wb_stage.
// Expected outputs come from an independent shift-based load model.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        mis;
    logic        dcare;
  } exp_t;

  logic clk;
  logic reset;
  logic stall;
  logic flush;

  int passed;
  int total;

  exp_t sb[$];
  exp_t cur;

  mem_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic        v,
    input logic        rw,
    input logic        m2r,
    input logic [2:0]  lt,
    input logic [1:0]  off,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [4:0]  rd
  );
    exp_t        e;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] x;
    logic        mis;
    b = (mem >> (8 * int'(off))) & 32'h0000_00FF;
    h = (mem >> (16 * int'(off[1]))) & 32'h0000_FFFF;
    case (lt)
      3'b000: begin x = b; if (b[7]) x = x | 32'hFFFF_FF00; end
      3'b001: begin x = h; if (h[15]) x = x | 32'hFFFF_0000; end
      3'b100: x = b;
      3'b101: x = h;
      default: x = mem;
    endcase
    case (lt)
      3'b000, 3'b100: mis = 1'b0;
      3'b001, 3'b101: mis = off[0];
      default:        mis = (off != 2'b00);
    endcase
    mis = mis & v & m2r;
    e.v     = v;
    e.we    = v & rw & (rd != 5'd0) & ~mis;
    e.rd    = rd;
    e.d     = m2r ? x : alu;
    e.mis   = mis;
    e.dcare = mis;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic drive(
    input logic        v,
    input logic        rw,
    input logic        m2r,
    input logic [2:0]  lt,
    input logic [1:0]  off,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [4:0]  rd
  );
    bus.in_valid      = v;
    bus.reg_write_in  = rw;
    bus.mem_to_reg_in = m2r;
    bus.load_type_in  = lt;
    bus.byte_off_in   = off;
    bus.alu_result_in = alu;
    bus.mem_data_in   = mem;
    bus.rd_in         = rd;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    if (reset || flush) cur = '0;
    else if (!stall)
      cur = model(bus.in_valid, bus.reg_write_in, bus.mem_to_reg_in,
                  bus.load_type_in, bus.byte_off_in,
                  bus.alu_result_in, bus.mem_data_in, bus.rd_in);
    sb.push_back(cur);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".valid"}, 32'(bus.wb_valid), 32'(e.v));
    chk({tag, ".we"}, 32'(bus.wb_reg_write), 32'(e.we));
    chk({tag, ".rd"}, 32'(bus.wb_rd), 32'(e.rd));
    chk({tag, ".mis"}, 32'(bus.wb_misalign), 32'(e.mis));
    if (!e.dcare) chk({tag, ".data"}, bus.wb_data, e.d);
  endtask

  localparam logic [31:0] MD = 32'h80FF_7F01;

  initial begin
    passed = 0;
    total  = 0;
    cur    = '0;
    reset  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 32'hDEAD_BEEF, MD, 5'd9);
    tick("reset");
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 5'd0);
    tick("idle0");
    tick("idle1");

    drive(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_1234, MD, 5'd3);
    tick("alu");
    drive(1'b1, 1'b1, 1'b1, 3'b000, 2'd3, 32'h0, MD, 5'd4);
    tick("lb3");
    drive(1'b1, 1'b1, 1'b1, 3'b100, 2'd3, 32'h0, MD, 5'd4);
    tick("lbu3");
    drive(1'b1, 1'b1, 1'b1, 3'b000, 2'd1, 32'h0, MD, 5'd4);
    tick("lb1");
    drive(1'b1, 1'b1, 1'b1, 3'b001, 2'd2, 32'h0, MD, 5'd4);
    tick("lh2");
    drive(1'b1, 1'b1, 1'b1, 3'b101, 2'd0, 32'h0, MD, 5'd4);
    tick("lhu0");
    drive(1'b1, 1'b1, 1'b1, 3'b101, 2'd2, 32'h0, MD, 5'd4);
    tick("lhu2");
    drive(1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 32'h0, MD, 5'd4);
    tick("lb0");
    drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, MD, 5'd4);
    tick("lw0");
    drive(1'b1, 1'b1, 1'b1, 3'b011, 2'd0, 32'h0, MD, 5'd4);
    tick("rsv0");
    drive(1'b1, 1'b1, 1'b1, 3'b001, 2'd1, 32'h0, MD, 5'd5);
    tick("lh1mis");
    drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd2, 32'h0, MD, 5'd5);
    tick("lw2mis");
    drive(1'b1, 1'b1, 1'b1, 3'b111, 2'd1, 32'h0, MD, 5'd5);
    tick("rsv1mis");
    drive(1'b1, 1'b1, 1'b0, 3'b001, 2'd1, 32'h0000_0055, MD, 5'd5);
    tick("alu_nomis");
    drive(1'b0, 1'b1, 1'b1, 3'b010, 2'd1, 32'h0, MD, 5'd6);
    tick("inv_nomis");
    drive(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_0077, MD, 5'd0);
    tick("rd0");
    drive(1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_0066, MD, 5'd8);
    tick("invalid");

    drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'hA5A5_A5A5, 5'd7);
    tick("st_load");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'b000, 2'(i), 32'h1111_0000 + i, MD, 5'(i + 10));
      tick("st_hold");
    end
    flush = 1'b1;
    tick("st_flush");
    flush = 1'b0;
    stall = 1'b0;

    drive(1'b1, 1'b1, 1'b1, 3'b101, 2'd3, 32'h0, MD, 5'd12);
    tick("mis_load");
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 32'h2, MD, 5'd13);
    tick("mis_hold");
    stall = 1'b0;
    tick("mis_clear");

    drive(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_BEEF, MD, 5'd14);
    tick("rs_load");
    stall = 1'b1;
    tick("rs_hold");
    reset = 1'b1;
    tick("rs_reset");
    reset = 1'b0;
    stall = 1'b0;

    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 2'($urandom), $urandom, $urandom,
            5'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 19) == 0);
      tick("rand");
    end
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
